// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage between EX_MEM and MEM_WB.
// Byte-addressable, little-endian data memory with byte/half/word access,
// load sign/zero extension, misalignment detection and a sticky fault log.
//
// Ports:
//   i_clock       pipeline clock, all state on posedge
//   i_reset       synchronous active-high reset, clears memory and fault log
//   i_address     byte address (ALU result)
//   i_writedata   store data; sub-word stores use the low bits
//   i_memread     load enable
//   i_memwrite    store enable
//   i_size        00 byte, 01 half, 11 word, 10 treated as word
//   i_unsigned    1 = zero-extend sub-word loads, 0 = sign-extend
//   i_debug_addr  word index for the debug read port
//   o_dataread    extended load result (combinational)
//   o_misaligned  current access is misaligned (combinational)
//   o_fault       sticky misalignment flag
//   o_fault_addr  byte address of the first faulting access
//   o_debug_data  raw word at i_debug_addr (combinational)
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_BITS  = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_writedata,
    input  logic                  i_memread,
    input  logic                  i_memwrite,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_BITS-1:0]  i_debug_addr,
    output logic [DATA_WIDTH-1:0] o_dataread,
    output logic                  o_misaligned,
    output logic                  o_fault,
    output logic [DATA_WIDTH-1:0] o_fault_addr,
    output logic [DATA_WIDTH-1:0] o_debug_data
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  fault_q;
    logic [DATA_WIDTH-1:0] fault_addr_q;

    logic [ADDR_BITS-1:0]  word_idx;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  store_en;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    // Address bits above the memory span are ignored, so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_address[DATA_WIDTH-1:ADDR_BITS+2];

    assign word_idx = i_address[ADDR_BITS+1:2];
    assign lane     = i_address[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    end

    assign o_misaligned = (i_memread | i_memwrite) & misaligned;
    assign store_en     = i_memwrite & ~misaligned;

    // Replicate sub-word store data across lanes; byte enables pick the target.
    always_comb begin
        wr_be   = 4'b1111;
        wr_word = i_writedata;
        case (i_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_word = {4{i_writedata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{i_writedata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = i_writedata;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            if (store_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                    end
                end
            end
            // Only the first fault is logged until the next reset.
            if (o_misaligned && !fault_q) begin
                fault_q      <= 1'b1;
                fault_addr_q <= i_address;
            end
        end
    end

    // Pre-write contents: a simultaneous store only lands on the clock edge.
    assign rd_word = mem_q[word_idx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        o_dataread = '0;
        if (i_memread && !misaligned) begin
            case (i_size)
                2'b00:   o_dataread = {{(DATA_WIDTH-8){~i_unsigned & ld_byte[7]}}, ld_byte};
                2'b01:   o_dataread = {{(DATA_WIDTH-16){~i_unsigned & ld_half[15]}}, ld_half};
                default: o_dataread = rd_word;
            endcase
        end
    end

    assign o_fault      = fault_q;
    assign o_fault_addr = fault_addr_q;
    assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int unsigned NBytes = 1024;  // 4 * MEM_DEPTH

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  dbg;
    logic [31:0] dataread;
    logic        misaligned;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] debug_data;

    mem_stage #(
        .DATA_WIDTH(32),
        .MEM_DEPTH (256),
        .ADDR_BITS (8)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_address   (addr),
        .i_writedata (wdata),
        .i_memread   (rd),
        .i_memwrite  (wr),
        .i_size      (size),
        .i_unsigned  (uns),
        .i_debug_addr(dbg),
        .o_dataread  (dataread),
        .o_misaligned(misaligned),
        .o_fault     (fault),
        .o_fault_addr(fault_addr),
        .o_debug_data(debug_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: flat byte array plus fault log.
    logic [7:0]  m_mem [NBytes];
    logic        m_fault;
    logic [31:0] m_fault_addr;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [31:0] exp_load();
        int n;
        int base;
        logic [31:0] v;
        n = nbytes(size);
        if (!rd || is_mis(addr, size)) return 32'h0;
        base = int'(addr % NBytes);
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(m_mem[base + k]) << (8 * k));
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] exp_debug();
        int b;
        b = 4 * int'(dbg);
        return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBytes; i++) m_mem[i] = 8'h00;
            m_fault      = 1'b0;
            m_fault_addr = 32'h0;
        end else begin
            if ((rd || wr) && is_mis(addr, size) && !m_fault) begin
                m_fault      = 1'b1;
                m_fault_addr = addr;
            end
            if (wr && !is_mis(addr, size)) begin
                for (int k = 0; k < nbytes(size); k++)
                    m_mem[int'((addr + k) % NBytes)] = wdata[8*k +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("dataread",   dataread,           exp_load());
            check("misaligned", {31'b0, misaligned}, {31'b0, (rd | wr) & is_mis(addr, size)});
            check("fault",      {31'b0, fault},      {31'b0, m_fault});
            check("fault_addr", fault_addr,          m_fault_addr);
            check("debug_data", debug_data,          exp_debug());
        end
    end

    // Inputs change 1 time unit after posedge; literal checks follow the negedge.
    task automatic op(input logic r, input logic dr, input logic dw, input logic [1:0] s,
                      input logic u, input logic [31:0] a, input logic [31:0] d,
                      input logic [7:0] di);
        @(posedge clk);
        #1;
        rst = r; rd = dr; wr = dw; size = s; uns = u; addr = a; wdata = d; dbg = di;
        @(negedge clk);
        #1;
    endtask

    localparam logic [1:0] SzB = 2'b00;
    localparam logic [1:0] SzH = 2'b01;
    localparam logic [1:0] SzW = 2'b11;

    initial begin
        rst = 1'b1; rd = 0; wr = 0; size = SzW; uns = 0; addr = 0; wdata = 0; dbg = 0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1;

        // Post-reset state
        op(0, 0, 0, SzW, 0, 32'h0, 32'h0, 8'd0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        check("rst_debug", debug_data, 32'h0);
        op(0, 1, 0, SzW, 0, 32'h0, 32'h0, 8'd0);
        check("rst_dataread", dataread, 32'h0);

        // Word store/load
        op(0, 0, 1, SzW, 0, 32'h10, 32'hDEADBEEF, 8'd4);
        op(0, 1, 0, SzW, 0, 32'h10, 32'h0, 8'd4);
        check("lw_10", dataread, 32'hDEADBEEF);
        check("dbg_4", debug_data, 32'hDEADBEEF);

        // Byte lanes; upper write-data bits must be ignored
        op(0, 0, 1, SzB, 0, 32'h20, 32'hFFFFFF11, 8'd8);
        op(0, 0, 1, SzB, 0, 32'h21, 32'hABCDEF22, 8'd8);
        op(0, 0, 1, SzB, 0, 32'h22, 32'h00000033, 8'd8);
        op(0, 0, 1, SzB, 0, 32'h23, 32'h12345680, 8'd8);
        op(0, 1, 0, SzW, 0, 32'h20, 32'h0, 8'd8);
        check("lw_20", dataread, 32'h80332211);
        op(0, 1, 0, SzB, 0, 32'h23, 32'h0, 8'd8);
        check("lb_23", dataread, 32'hFFFFFF80);
        op(0, 1, 0, SzB, 1, 32'h23, 32'h0, 8'd8);
        check("lbu_23", dataread, 32'h00000080);
        op(0, 1, 0, SzB, 0, 32'h21, 32'h0, 8'd8);
        check("lb_21", dataread, 32'h00000022);

        // Halfword
        op(0, 0, 1, SzW, 0, 32'h30, 32'hAAAAAAAA, 8'd12);
        op(0, 0, 1, SzH, 0, 32'h32, 32'h12348001, 8'd12);
        op(0, 1, 0, SzW, 0, 32'h30, 32'h0, 8'd12);
        check("lw_30", dataread, 32'h8001AAAA);
        op(0, 1, 0, SzH, 0, 32'h32, 32'h0, 8'd12);
        check("lh_32", dataread, 32'hFFFF8001);
        op(0, 1, 0, SzH, 1, 32'h32, 32'h0, 8'd12);
        check("lhu_32", dataread, 32'h00008001);
        op(0, 1, 0, SzH, 0, 32'h30, 32'h0, 8'd12);
        check("lh_30", dataread, 32'hFFFFAAAA);

        // Misalignment and sticky fault log
        op(0, 0, 1, SzW, 0, 32'h41, 32'h12345678, 8'd16);
        check("mis_sw_41", {31'b0, misaligned}, 32'h1);
        check("mis_fault_pre", {31'b0, fault}, 32'h0);
        op(0, 0, 0, SzW, 0, 32'h40, 32'h0, 8'd16);
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_fault_addr", fault_addr, 32'h41);
        check("mis_mem_40", debug_data, 32'h0);
        op(0, 1, 0, SzH, 0, 32'h43, 32'h0, 8'd16);
        check("mis_lh_43", {31'b0, misaligned}, 32'h1);
        check("mis_lh_data", dataread, 32'h0);
        op(0, 0, 0, SzW, 0, 32'h0, 32'h0, 8'd16);
        check("mis_sticky", fault_addr, 32'h41);
        op(0, 1, 0, 2'b10, 0, 32'h42, 32'h0, 8'd16);
        check("mis_rsvd_word", {31'b0, misaligned}, 32'h1);

        // Wrap and simultaneous read/write
        op(0, 0, 1, SzW, 0, 32'h400, 32'h55, 8'd0);
        op(0, 1, 0, SzW, 0, 32'h0, 32'h0, 8'd0);
        check("wrap_lw_0", dataread, 32'h55);
        op(0, 1, 1, SzW, 0, 32'h0, 32'h66, 8'd0);
        check("rw_old", dataread, 32'h55);
        op(0, 1, 0, SzW, 0, 32'h0, 32'h0, 8'd0);
        check("rw_new", dataread, 32'h66);

        // Reset dominates a concurrent store
        op(1, 0, 1, SzW, 0, 32'h8, 32'h77, 8'd2);
        op(0, 1, 0, SzW, 0, 32'h8, 32'h0, 8'd2);
        check("rst_lw_8", dataread, 32'h0);
        check("rst_fault2", {31'b0, fault}, 32'h0);
        check("rst_fault_addr2", fault_addr, 32'h0);
        for (int k = 0; k < 256; k++) op(0, 0, 0, SzW, 0, 32'h0, 32'h0, 8'(k));
        check("rst_dbg_last", debug_data, 32'h0);

        @(posedge clk);
        #1;
        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
